// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared constants and FSM encoding for the fetch PC stage
package pc_gen_pkg;
  localparam logic STOP = 1'b1;
  localparam logic NO_STOP = 1'b0;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'hBFC0_0000;
  localparam int INST_BYTES_DEF = 4;
  typedef enum logic [1:0] {BOOT, RUN, HOLD} pc_state_e;
endpackage

// File: rtl/pc_redirect_buf.sv
// pc_redirect_buf: pending redirect target plus valid bit; clear beats set/overwrite
module pc_redirect_buf
  import pc_gen_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         set,
  input  logic         ovr,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      valid <= 1'b0;
      q <= W'(ZERO_WORD);
    end else if (set || ovr) begin
      valid <= 1'b1;
      q <= d;
    end
  end
endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch PC owner; buffers redirects that arrive during a stall.
// Define PC_ALIGN_CHECK_EN to add o_adel and block fetch of misaligned PCs.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int PC_W = 32,
  parameter logic [PC_W-1:0] RESET_VECTOR = PC_W'(RESET_VECTOR_DEF),
  parameter int STALL_W = 6,
  parameter int INST_BYTES = INST_BYTES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [PC_W-1:0]    flush_pc,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    br_target,
  output logic               inst_req,
  input  logic               inst_addr_ok,
  output logic [PC_W-1:0]    o_pc,
  output logic               o_valid,
  output logic               o_pend
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic               o_adel
`endif
);
  pc_state_e state, state_nxt;
  logic [PC_W-1:0] pc_nxt, pend_pc;
  logic valid_nxt, pend_set, pend_ovr, pend_clr, frz, adv, bub;
  logic unused_stall;
  assign unused_stall = ^stall;
`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk) o_adel <= reset ? 1'b0 : |pc_nxt[1:0];
  assign frz = o_adel;
`else
  assign frz = 1'b0;
`endif
  pc_redirect_buf #(.W(PC_W)) u_buf (
    .clk(clk), .reset(reset), .set(pend_set), .ovr(pend_ovr), .clr(pend_clr),
    .d(br_target), .valid(o_pend), .q(pend_pc)
  );
  assign inst_req = (state == RUN) && o_valid && stall[0] == NO_STOP && !frz;
  assign adv = (state == RUN) && stall[0] == NO_STOP && !frz && ((inst_req && inst_addr_ok) || !o_valid);
  assign bub = stall[0] == STOP && stall[1] == NO_STOP;
  // A branch that cannot be taken this cycle (stalled or unaccepted) is parked in HOLD.
  always_comb begin
    state_nxt = state;
    pc_nxt = o_pc;
    valid_nxt = o_valid;
    pend_set = 1'b0;
    pend_ovr = 1'b0;
    pend_clr = 1'b0;
    if (flush) begin
      pc_nxt = flush_pc;
      valid_nxt = 1'b1;
      pend_clr = 1'b1;
      state_nxt = RUN;
    end else if (frz) begin
      state_nxt = state;
    end else if (state == BOOT) begin
      valid_nxt = 1'b1;
      state_nxt = RUN;
    end else if (state == HOLD) begin
      if (stall[0] == NO_STOP) begin
        pc_nxt = br_taken ? br_target : pend_pc;
        valid_nxt = 1'b1;
        pend_clr = 1'b1;
        state_nxt = RUN;
      end else begin
        pend_ovr = br_taken;
        valid_nxt = bub ? 1'b0 : o_valid;
      end
    end else if (br_taken && !adv) begin
      pend_set = 1'b1;
      state_nxt = HOLD;
      valid_nxt = bub ? 1'b0 : o_valid;
    end else if (adv) begin
      pc_nxt = br_taken ? br_target : o_pc + PC_W'(INST_BYTES);
      valid_nxt = 1'b1;
    end else begin
      valid_nxt = bub ? 1'b0 : o_valid;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BOOT;
      o_pc <= RESET_VECTOR;
      o_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      o_pc <= pc_nxt;
      o_valid <= valid_nxt;
    end
  end
endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised successor to the single-register PC stage of the MIPS pipeline.
- Owns the fetch PC and holds a redirect (exception flush or branch) that arrives while fetch is stalled, then applies it when the stall releases.
- Adds an address-phase handshake to the instruction SRAM-like interface and inserts bubbles when fetch stops but decode does not.
- Sits between the ctrl/stall unit and the IF stage.

Parameters:
- RESET_VECTOR, 32'hBFC0_0000, PC loaded on reset.
- PC_W, 32, PC width; PC_W >= 3.
- STALL_W, 6, width of the stall vector from ctrl.
- INST_BYTES, 4, sequential PC increment.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- stall  in  STALL_W  stall vector; bit0 = PC stage, bit1 = IF stage; 1 = stop
- flush  in  1  exception/eret redirect, highest priority
- flush_pc  in  PC_W  target of flush
- br_taken  in  1  branch/jump redirect from ID
- br_target  in  PC_W  branch target
- inst_req  out  1  fetch request valid
- inst_addr_ok  in  1  memory accepted the address this cycle
- o_pc  out  PC_W  current fetch PC, driven as the request address
- o_valid  out  1  o_pc is a real instruction (0 = bubble)
- o_pend  out  1  a redirect is held

Behaviour:
- Reset (synchronous, active-high):
  - o_pc = RESET_VECTOR; o_valid = 0; o_pend = 0; pending register = 0; state = BOOT.
  - Reset overrides every other input.
- States:
  - BOOT: after reset, one cycle; inst_req = 0; then go to RUN with o_valid = 1. o_pc keeps RESET_VECTOR.
  - RUN: inst_req = o_valid & ~stall[0].
  - HOLD: a redirect is latched in the pending register; inst_req = 0; o_pend = 1.
- "advance" = state RUN, ~stall[0], and either (inst_req & inst_addr_ok) or ~o_valid.
- Next-PC priority (RUN):
  1. flush: o_pc <= flush_pc and o_valid <= 1 next cycle, regardless of stall or handshake. Clears the pending register. Discards a request not yet accepted.
  2. br_taken with stall[0] = 1: latch br_target into the pending register; go to HOLD.
  3. br_taken on an advance: o_pc <= br_target.
  4. Otherwise on an advance: o_pc <= o_pc + INST_BYTES, wrapping modulo 2^PC_W.
  5. No advance and no redirect: hold o_pc.
- HOLD:
  - flush overrides the pending target: load flush_pc, clear pending, go to RUN.
  - When stall[0] = 0: o_pc <= pending; o_valid <= 1; go to RUN. Latency from stall release to the redirected PC is 1 cycle.
  - A new br_taken while in HOLD replaces the pending target (last writer wins).
- Bubble: stall[0] = 1 and stall[1] = 0 drives o_valid <= 0 and leaves o_pc unchanged. o_valid returns to 1 on the next advance or redirect.
- stall[0] = 1 and stall[1] = 1: all state is frozen except the flush/pending capture.
- inst_addr_ok while inst_req = 0 is ignored.
- Simultaneous flush and br_taken: flush wins and the branch is dropped.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - Adds output o_adel (1 bit, registered with o_pc, reset 0); o_adel = 1 when the loaded o_pc[1:0] != 0.
  - While o_adel = 1: inst_req = 0 and o_pc holds until flush.
- Undefined: no o_adel port, no alignment logic.

Decomposition:
- Shared package/header (global_define.vh): Stop/NoStop, ZeroWord, RESET_VECTOR default, the state encoding BOOT/RUN/HOLD, INST_BYTES.
- One sub-module, pc_redirect_buf: the pending target register plus valid bit, with set, overwrite and clear ports. The FSM and adder stay in pc_gen.

Test Plan:
- Reset, then inst_addr_ok = 1 constantly, stall = 0:
  - cycle 1: o_pc = BFC00000, inst_req = 0.
  - then BFC00000 held while inst_req = 0.
  - then BFC00004, BFC00008 on successive accepted cycles.
- inst_addr_ok low for 3 cycles while inst_req = 1 -> o_pc holds BFC00008 for all 3; advances to BFC0000C the cycle after ok = 1.
- br_taken = 1, target 80001000, during stall = 6'b000011 for 4 cycles:
  - o_pend = 1 and o_pc unchanged throughout.
  - one cycle after stall clears: o_pc = 80001000, o_pend = 0.
- In HOLD with pending 80001000, flush = 1, flush_pc = BFC00380 -> next cycle o_pc = BFC00380, o_pend = 0; the branch target is never fetched.
- stall = 6'b000001 -> o_valid = 0 next cycle, o_pc unchanged; stall = 0 -> o_valid = 1, sequential advance resumes.
- PC_ALIGN_CHECK_EN defined, br_target 80001002 -> o_adel = 1, inst_req = 0 until flush; with the macro undefined, o_pc = 80001002 and fetch proceeds.
